// File: rtl/mem_port_if.sv
// Bundles the fetch, data and memory-side signals of the shared memory port.
// The arbiter takes the slave view; the CPU and memory together form the master side.
interface mem_port_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output if_rdata, if_ack, d_rdata, d_ack, err, mem_en, mem_we, mem_addr, mem_wdata, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_ack, d_rdata, d_ack, err, mem_en, mem_we, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store traffic.
// One access at a time, data side first, registered outputs, timeout reported as an error ack.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic      clock,
   input  logic      reset,
   mem_port_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_s;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] if_rdata_s;
   logic [DATA_W-1:0] d_rdata_r;
   logic [DATA_W-1:0] d_rdata_s;
   logic              if_ack_r;
   logic              if_ack_s;
   logic              d_ack_r;
   logic              d_ack_s;
   logic              err_r;
   logic              err_s;
   logic              mem_en_r;
   logic              mem_en_s;
   logic              mem_we_r;
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] mem_wdata_s;
   logic              busy_r;
   logic              timeout_s;

   // The edge on which the counter would reach TIMEOUT is the one that gives up.
   assign timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state, wait counter and next values of every registered output.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      if_rdata_s  = if_rdata_r;
      d_rdata_s   = d_rdata_r;
      if_ack_s    = 1'b0;
      d_ack_s     = 1'b0;
      err_s       = 1'b0;
      mem_en_s    = mem_en_r;
      mem_we_s    = mem_we_r;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      case (state_r)
         IDLE: begin
            if (bus.d_req) begin
               mem_addr_s  = bus.d_addr;
               mem_we_s    = bus.d_we;
               mem_wdata_s = bus.d_wdata;
               mem_en_s    = 1'b1;
               cnt_s       = '0;
               state_s     = BUSY_D;
            end else if (bus.if_req) begin
               mem_addr_s = bus.if_addr;
               mem_we_s   = 1'b0;
               mem_en_s   = 1'b1;
               cnt_s      = '0;
               state_s    = BUSY_I;
            end else begin
               state_s = IDLE;
            end
         end
         BUSY_I: begin
            if (bus.mem_ready) begin
               if_rdata_s = bus.mem_rdata;
               if_ack_s   = 1'b1;
               mem_en_s   = 1'b0;
               mem_we_s   = 1'b0;
               state_s    = IDLE;
            end else if (timeout_s) begin
               if_rdata_s = '0;
               if_ack_s   = 1'b1;
               err_s      = 1'b1;
               mem_en_s   = 1'b0;
               mem_we_s   = 1'b0;
               state_s    = IDLE;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         BUSY_D: begin
            if (bus.mem_ready) begin
               // A store leaves the last load result visible.
               if (!mem_we_r) begin
                  d_rdata_s = bus.mem_rdata;
               end else begin
                  d_rdata_s = d_rdata_r;
               end
               d_ack_s  = 1'b1;
               mem_en_s = 1'b0;
               mem_we_s = 1'b0;
               state_s  = IDLE;
            end else if (timeout_s) begin
               d_rdata_s = '0;
               d_ack_s   = 1'b1;
               err_s     = 1'b1;
               mem_en_s  = 1'b0;
               mem_we_s  = 1'b0;
               state_s   = IDLE;
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            mem_en_s = 1'b0;
            mem_we_s = 1'b0;
            state_s  = IDLE;
         end
      endcase
   end

   // Output and counter registers; reset aborts any access without an ack.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r       <= '0;
         if_rdata_r  <= '0;
         d_rdata_r   <= '0;
         if_ack_r    <= 1'b0;
         d_ack_r     <= 1'b0;
         err_r       <= 1'b0;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         busy_r      <= 1'b0;
      end else begin
         cnt_r       <= cnt_s;
         if_rdata_r  <= if_rdata_s;
         d_rdata_r   <= d_rdata_s;
         if_ack_r    <= if_ack_s;
         d_ack_r     <= d_ack_s;
         err_r       <= err_s;
         mem_en_r    <= mem_en_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         busy_r      <= (state_s != IDLE);
      end
   end

   assign bus.if_rdata  = if_rdata_r;
   assign bus.if_ack    = if_ack_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.d_ack     = d_ack_r;
   assign bus.err       = err_r;
   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;
   assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory responder checks the bus per access,
// a monitor pops expected acks from a scoreboard queue.
module tb_mem_port_arbiter;
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      int          cycles;
   } mem_exp_t;

   typedef struct {
      bit          is_d;
      logic [31:0] rdata;
      bit          err;
   } ack_exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   n;

   mem_exp_t exp_mem[$];
   ack_exp_t sb[$];

   mem_exp_t cur;
   bit       have_cur;
   bit       en_prev;
   int       en_cnt;

   mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
      end
   endtask

   // Memory model: serves accesses in the expected order and checks the bus every busy cycle.
   initial begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'd0;
      have_cur = 1'b0;
      en_prev  = 1'b0;
      en_cnt   = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_en === 1'b1) begin
            if (!en_prev) begin
               en_cnt = 0;
               if (exp_mem.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_mem_en act=1 exp=0");
                  have_cur = 1'b0;
               end else begin
                  cur = exp_mem.pop_front();
                  have_cur = 1'b1;
               end
            end
            en_cnt++;
            if (have_cur) begin
               chk("mem_addr", {32'd0, bus.mem_addr}, {32'd0, cur.addr});
               chk("mem_we_busy", {62'd0, bus.mem_we, bus.busy}, {62'd0, cur.we, 1'b1});
               if (cur.we) chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, cur.wdata});
               if (cur.lat != 0 && en_cnt == cur.lat) begin
                  bus.mem_ready = 1'b1;
                  bus.mem_rdata = cur.rdata;
               end else begin
                  bus.mem_ready = 1'b0;
                  bus.mem_rdata = 32'd0;
               end
            end else begin
               bus.mem_ready = 1'b0;
            end
         end else begin
            if (en_prev && have_cur) begin
               chk("mem_en_cycles", 64'(en_cnt), 64'(cur.cycles));
               have_cur = 1'b0;
            end
            bus.mem_ready = 1'b0;
            bus.mem_rdata = 32'd0;
         end
         en_prev = (bus.mem_en === 1'b1);
      end
   end

   // Ack monitor: every ack pulse must match the head of the scoreboard.
   initial begin
      ack_exp_t e;
      forever begin
         @(negedge clk);
         if (bus.if_ack === 1'b1 || bus.d_ack === 1'b1) begin
            if (bus.if_ack === 1'b1 && bus.d_ack === 1'b1) begin
               checks++;
               errors++;
               $display("FAIL dual_ack act=2 exp=1");
            end else if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack if_ack=%0b d_ack=%0b exp=none", bus.if_ack, bus.d_ack);
            end else begin
               e = sb.pop_front();
               chk("ack_kind", {63'd0, bus.d_ack}, {63'd0, e.is_d});
               chk("ack_rdata", {32'd0, (e.is_d ? bus.d_rdata : bus.if_rdata)}, {32'd0, e.rdata});
               chk("ack_err", {63'd0, bus.err}, {63'd0, e.err});
               chk("ack_idle", {62'd0, bus.mem_en, bus.busy}, 64'd0);
            end
         end else if (bus.err === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL err_without_ack act=1 exp=0");
         end
      end
   end

   task automatic wait_ack(input bit is_d, input int budget, output int cnt);
      bit done;
      cnt  = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         cnt++;
         if ((is_d ? bus.d_ack : bus.if_ack) === 1'b1) begin
            if (is_d) bus.d_req = 1'b0;
            else bus.if_req = 1'b0;
            done = 1'b1;
         end else if (cnt >= budget) begin
            checks++;
            errors++;
            $display("FAIL ack_wait_timeout is_d=%0b act=none exp=ack", is_d);
            if (is_d) bus.d_req = 1'b0;
            else bus.if_req = 1'b0;
            done = 1'b1;
         end
      end
   endtask

   task automatic check_quiet(input string name);
      @(negedge clk);
      chk(name, {59'd0, bus.if_ack, bus.d_ack, bus.err, bus.mem_en, bus.busy}, 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      chk({name, "_ctl"}, {58'd0, bus.if_ack, bus.d_ack, bus.err, bus.mem_en, bus.mem_we, bus.busy}, 64'd0);
      chk({name, "_rdata"}, {bus.if_rdata, bus.d_rdata}, 64'd0);
      chk({name, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.if_req = 1'b1;
      bus.if_addr = 32'h0000_000C;
      bus.d_req = 1'b1;
      bus.d_we = 1'b0;
      bus.d_addr = 32'h0000_0100;
      bus.d_wdata = 32'd0;

      // 1: reset with both requests pending, then data wins after release.
      exp_mem.push_back('{32'h100, 1'b0, 32'd0, 2, 32'hAAAA_0001, 2});
      exp_mem.push_back('{32'h00C, 1'b0, 32'd0, 1, 32'h0C0C_0C0C, 1});
      sb.push_back('{1'b1, 32'hAAAA_0001, 1'b0});
      sb.push_back('{1'b0, 32'h0C0C_0C0C, 1'b0});
      @(negedge clk);
      check_all_zero("reset1");
      @(negedge clk);
      check_all_zero("reset2");
      reset = 1'b0;
      wait_ack(1'b1, 20, n);
      chk("t1_d_latency", 64'(n), 64'd3);
      wait_ack(1'b0, 20, n);
      chk("t1_i_latency", 64'(n), 64'd2);
      check_quiet("t1_quiet");

      // 2: fetch with memory ready on the third busy cycle.
      bus.if_addr = 32'h0000_0010;
      bus.if_req = 1'b1;
      exp_mem.push_back('{32'h010, 1'b0, 32'd0, 3, 32'hF800_0000, 3});
      sb.push_back('{1'b0, 32'hF800_0000, 1'b0});
      wait_ack(1'b0, 20, n);
      chk("t2_latency", 64'(n), 64'd4);
      check_quiet("t2_pulse");

      // 3: simultaneous store and fetch; store first, one dead cycle, then fetch.
      bus.if_addr = 32'h0000_0004;
      bus.if_req = 1'b1;
      bus.d_addr = 32'h0000_0008;
      bus.d_we = 1'b1;
      bus.d_wdata = 32'h0000_0055;
      bus.d_req = 1'b1;
      exp_mem.push_back('{32'h008, 1'b1, 32'h55, 1, 32'hDEAD_BEEF, 1});
      exp_mem.push_back('{32'h004, 1'b0, 32'd0, 1, 32'h1111_0004, 1});
      sb.push_back('{1'b1, 32'hAAAA_0001, 1'b0});
      sb.push_back('{1'b0, 32'h1111_0004, 1'b0});
      wait_ack(1'b1, 20, n);
      chk("t3_d_latency", 64'(n), 64'd2);
      wait_ack(1'b0, 20, n);
      chk("t3_i_latency", 64'(n), 64'd2);
      check_quiet("t3_quiet");

      // 4: load that never completes times out on the ninth cycle after grant.
      bus.d_addr = 32'h0000_0040;
      bus.d_we = 1'b0;
      bus.d_req = 1'b1;
      exp_mem.push_back('{32'h040, 1'b0, 32'd0, 0, 32'd0, 8});
      sb.push_back('{1'b1, 32'd0, 1'b1});
      wait_ack(1'b1, 30, n);
      chk("t4_latency", 64'(n), 64'd9);
      check_quiet("t4_after");

      // 6: request dropped after one cycle still completes.
      bus.d_addr = 32'h0000_0020;
      bus.d_req = 1'b1;
      exp_mem.push_back('{32'h020, 1'b0, 32'd0, 4, 32'h0000_1234, 4});
      sb.push_back('{1'b1, 32'h0000_1234, 1'b0});
      @(negedge clk);
      bus.d_req = 1'b0;
      wait_ack(1'b1, 20, n);
      chk("t6_latency", 64'(n), 64'd4);
      check_quiet("t6_after");

      // 5: reset in the second busy cycle aborts the access silently.
      bus.d_addr = 32'h0000_0030;
      bus.d_req = 1'b1;
      exp_mem.push_back('{32'h030, 1'b0, 32'd0, 0, 32'd0, 2});
      @(negedge clk);
      chk("t5_granted", {62'd0, bus.mem_en, bus.busy}, 64'd3);
      @(negedge clk);
      reset = 1'b1;
      bus.d_req = 1'b0;
      @(negedge clk);
      check_all_zero("t5_abort");
      reset = 1'b0;
      repeat (12) check_quiet("t5_no_ack");

      chk("sb_drained", 64'(sb.size()), 64'd0);
      chk("mem_drained", 64'(exp_mem.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
